// File: rtl/mdu_pkg.sv
// ---------------------------------------------------------------------------
// mdu_pkg
// Shared definitions for the multiply/divide unit: operation encodings on the
// op bus, the two-state sequencing FSM and the width of the busy down-counter.
// ---------------------------------------------------------------------------
package mdu_pkg;

   // Operation encodings carried on op; 6 and 7 are reserved and ignored
   localparam logic [2:0] MDU_MULT  = 3'd0;
   localparam logic [2:0] MDU_MULTU = 3'd1;
   localparam logic [2:0] MDU_DIV   = 3'd2;
   localparam logic [2:0] MDU_DIVU  = 3'd3;
   localparam logic [2:0] MDU_MTHI  = 3'd4;
   localparam logic [2:0] MDU_MTLO  = 3'd5;

   // Width of the busy down-counter; cycle counts go up to 255
   localparam int CNT_W = 8;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } mdu_state_t;

endpackage

// File: rtl/mdu_arith.sv
// ---------------------------------------------------------------------------
// mdu_arith
// Purely combinational result generator for the multiply/divide unit.
// Ports:
//   op     : operation code (mdu_pkg encodings)
//   a, b   : operands (a = multiplicand/dividend, b = multiplier/divisor)
//   res_hi : HI result (product upper half or remainder)
//   res_lo : LO result (product lower half or quotient)
// ---------------------------------------------------------------------------
module mdu_arith
   import mdu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] res_hi,
   output logic [WIDTH-1:0] res_lo
);

   localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   logic [2*WIDTH-1:0] prodSigned;
   logic [2*WIDTH-1:0] prodUnsigned;
   logic [WIDTH-1:0]   quotSigned;
   logic [WIDTH-1:0]   remSigned;
   logic [WIDTH-1:0]   quotUnsigned;
   logic [WIDTH-1:0]   remUnsigned;

   // Full-width products: operands are extended to 2*WIDTH first so the
   // product keeps every bit; sign extension gives the two's-complement result.
   assign prodSigned   = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
   assign prodUnsigned = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

   // Signed division truncates toward zero with the remainder taking the
   // dividend's sign; divide-by-zero and overflow are overridden below.
   assign quotSigned   = $signed(a) / $signed(b);
   assign remSigned    = $signed(a) % $signed(b);
   assign quotUnsigned = a / b;
   assign remUnsigned  = a % b;

   // Result select: a zero divisor yields all-ones quotient with the dividend
   // as remainder; most-negative / -1 returns the dividend with no remainder.
   always_comb begin
      res_hi = '0;
      res_lo = '0;
      case (op)
         MDU_MULT: begin
            res_hi = prodSigned[2*WIDTH-1:WIDTH];
            res_lo = prodSigned[WIDTH-1:0];
         end
         MDU_MULTU: begin
            res_hi = prodUnsigned[2*WIDTH-1:WIDTH];
            res_lo = prodUnsigned[WIDTH-1:0];
         end
         MDU_DIV: begin
            if (b == '0) begin
               res_hi = a;
               res_lo = '1;
            end else if ((a == MOST_NEG) && (b == '1)) begin
               res_hi = '0;
               res_lo = a;
            end else begin
               res_hi = remSigned;
               res_lo = quotSigned;
            end
         end
         MDU_DIVU: begin
            if (b == '0) begin
               res_hi = a;
               res_lo = '1;
            end else begin
               res_hi = remUnsigned;
               res_lo = quotUnsigned;
            end
         end
         default: begin
            res_hi = '0;
            res_lo = '0;
         end
      endcase
   end

endmodule

// File: rtl/mdu.sv
// ---------------------------------------------------------------------------
// mdu
// Multiply/divide unit holding the architectural HI/LO registers. Results are
// computed at acceptance and held in pending registers; they are committed to
// HI/LO after a fixed number of busy cycles unless cancelled or reset.
// Ports:
//   clk    : clock, rising edge
//   reset  : asynchronous active-low reset
//   start  : issue op with operands a, b (ignored while busy or cancelling)
//   op     : operation code (mdu_pkg encodings)
//   a, b   : operands
//   cancel : abort the in-flight operation, discarding its result
//   busy   : high while a multiply/divide is in flight
//   hi, lo : architectural HI/LO registers
// ---------------------------------------------------------------------------
module mdu
   import mdu_pkg::*;
#(
   parameter int WIDTH       = 32,
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cancel,
   output logic             busy,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_CYCLES);
   localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   mdu_state_t       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] pendHi_q, pendHi_d;
   logic [WIDTH-1:0] pendLo_q, pendLo_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic [WIDTH-1:0] resHi;
   logic [WIDTH-1:0] resLo;

   mdu_arith #(
      .WIDTH (WIDTH)
   ) u_arith (
      .op     (op),
      .a      (a),
      .b      (b),
      .res_hi (resHi),
      .res_lo (resLo)
   );

   // State register: reset clears everything at once, so an in-flight result
   // held in the pending registers is lost.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         pendHi_q <= '0;
         pendLo_q <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         pendHi_q <= pendHi_d;
         pendLo_q <= pendLo_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
      end
   end

   // Next-state logic: in IDLE, an accepted multiply/divide captures its
   // result and loads the cycle count, while MTHI/MTLO write straight through.
   // In BUSY, cancel takes priority over the commit on the final count.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      pendHi_d = pendHi_q;
      pendLo_d = pendLo_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      case (state_q)
         IDLE: begin
            if (start && !cancel) begin
               case (op)
                  MDU_MULT, MDU_MULTU: begin
                     pendHi_d = resHi;
                     pendLo_d = resLo;
                     cnt_d    = MULT_CNT;
                     state_d  = BUSY;
                  end
                  MDU_DIV, MDU_DIVU: begin
                     pendHi_d = resHi;
                     pendLo_d = resLo;
                     cnt_d    = DIV_CNT;
                     state_d  = BUSY;
                  end
                  MDU_MTHI: hi_d = a;
                  MDU_MTLO: lo_d = a;
                  default: begin
                     state_d = IDLE;
                  end
               endcase
            end
         end
         BUSY: begin
            if (cancel) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_q == CNT_ONE) begin
               hi_d    = pendHi_q;
               lo_d    = pendLo_q;
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   assign busy = (state_q == BUSY);
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule
